midi_burst_serializer: RTL and testbench

// Takes one captured burst of up to 5 note-off and 5 note-on messages and re-emits it as a standard MIDI serial stream.

---
 rtl/midi_burst_serializer_if.sv | 22 ++
 rtl/midi_burst_serializer.sv | 161 ++++++++++++++++
 tb/tb_midi_burst_serializer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/midi_burst_serializer_if.sv
// Burst hand-off from the note collector plus the serial MIDI output status lines.
interface midi_burst_serializer_if;
  logic [20:0] burst_notes_on_in  [5];
  logic [20:0] burst_notes_off_in [5];
  logic [2:0]  on_msg_count_in;
  logic [2:0]  off_msg_count_in;
  logic        burst_ready_in;
  logic        midi_tx_out;
  logic        busy_out;
  logic        burst_done_out;
  logic        dropped_out;

  modport master (
    output burst_notes_on_in, burst_notes_off_in, on_msg_count_in, off_msg_count_in, burst_ready_in,
    input  midi_tx_out, busy_out, burst_done_out, dropped_out
  );

  modport slave (
    input  burst_notes_on_in, burst_notes_off_in, on_msg_count_in, off_msg_count_in, burst_ready_in,
    output midi_tx_out, busy_out, burst_done_out, dropped_out
  );
endinterface

// File: rtl/midi_burst_serializer.sv
// Replays one captured burst (note-offs first, then note-ons) as an 8N1 MIDI byte stream.
module midi_burst_serializer #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned BAUD_RATE = 31_250
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  midi_burst_serializer_if.slave bus
);
  localparam int unsigned BIT_CYCLES = CLK_HZ / BAUD_RATE;
  localparam int unsigned TW         = $clog2(BIT_CYCLES);
  localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_CYCLES - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(BIT_CYCLES - 2);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, NEXT_BYTE, DONE} state_t;
  state_t state, state_next;

  // Buffered entries keep only {chan, note[6:0], vel[6:0]}
  logic [17:0]   on_buf  [5];
  logic [17:0]   off_buf [5];
  logic [2:0]    on_n, off_n;
  logic [3:0]    total;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [1:0]    byte_idx;
  logic [3:0]    msg_idx;
  logic          is_on;
  logic [3:0]    sel;
  logic [17:0]   entry;
  logic [7:0]    cur_byte;
  logic          tx_d, done_d, drop_d;
  logic          tx_q, done_q, drop_q;
  logic [5:0]    unused_fields;

  function automatic logic [2:0] clamp5(input logic [2:0] c);
    return (c > 3'd5) ? 3'd5 : c;
  endfunction

  assign total = {1'b0, off_n} + {1'b0, on_n};

  always_comb begin
    unused_fields = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      unused_fields = unused_fields ^ {bus.burst_notes_on_in[i][20], bus.burst_notes_on_in[i][15],
                                       bus.burst_notes_on_in[i][7], bus.burst_notes_off_in[i][20],
                                       bus.burst_notes_off_in[i][15], bus.burst_notes_off_in[i][7]};
    end
  end

  always_comb begin
    is_on = (msg_idx >= {1'b0, off_n});
    sel   = is_on ? (msg_idx - {1'b0, off_n}) : msg_idx;
    entry = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (sel == 4'(i)) entry = is_on ? on_buf[i] : off_buf[i];
    end
    case (byte_idx)
      2'd0:    cur_byte = {1'b1, 2'b00, is_on, entry[17:14]};
      2'd1:    cur_byte = {1'b0, entry[13:7]};
      default: cur_byte = {1'b0, entry[6:0]};
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_next;
  end

  // STOP runs one cycle short; NEXT_BYTE supplies the final stop-bit cycle so frames abut
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (bus.burst_ready_in) state_next = LOAD;
      LOAD:      state_next = (total == 4'd0) ? DONE : START;
      START:     if (timer == BIT_LAST) state_next = DATA;
      DATA:      if (timer == BIT_LAST && bit_idx == 3'd7) state_next = STOP;
      STOP:      if (timer == STOP_LAST) state_next = NEXT_BYTE;
      NEXT_BYTE: state_next = (byte_idx == 2'd2 && (msg_idx + 4'd1) == total) ? DONE : START;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    unique case (state)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_idx];
      default: tx_d = 1'b1;
    endcase
    done_d = (state == DONE);
    drop_d = bus.burst_ready_in && (state != IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int unsigned i = 0; i < 5; i++) begin
        on_buf[i]  <= '0;
        off_buf[i] <= '0;
      end
      on_n     <= '0;
      off_n    <= '0;
      timer    <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      msg_idx  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.burst_ready_in) begin
          for (int unsigned i = 0; i < 5; i++) begin
            on_buf[i]  <= {bus.burst_notes_on_in[i][19:16], bus.burst_notes_on_in[i][14:8],
                           bus.burst_notes_on_in[i][6:0]};
            off_buf[i] <= {bus.burst_notes_off_in[i][19:16], bus.burst_notes_off_in[i][14:8],
                           bus.burst_notes_off_in[i][6:0]};
          end
          on_n  <= clamp5(bus.on_msg_count_in);
          off_n <= clamp5(bus.off_msg_count_in);
        end
        LOAD: begin
          msg_idx  <= '0;
          byte_idx <= '0;
          timer    <= '0;
          bit_idx  <= '0;
        end
        START: timer <= (timer == BIT_LAST) ? '0 : timer + TW'(1);
        DATA: begin
          timer <= (timer == BIT_LAST) ? '0 : timer + TW'(1);
          if (timer == BIT_LAST) bit_idx <= bit_idx + 3'd1;
        end
        STOP: timer <= (timer == STOP_LAST) ? '0 : timer + TW'(1);
        NEXT_BYTE: begin
          timer   <= '0;
          bit_idx <= '0;
          if (byte_idx == 2'd2) begin
            byte_idx <= '0;
            msg_idx  <= msg_idx + 4'd1;
          end else begin
            byte_idx <= byte_idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tx_q   <= 1'b1;
      done_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      done_q <= done_d;
      drop_q <= drop_d;
    end
  end

  assign bus.midi_tx_out    = tx_q;
  assign bus.busy_out       = (state != IDLE);
  assign bus.burst_done_out = done_q;
  assign bus.dropped_out    = drop_q;
endmodule

// File: tb/tb_midi_burst_serializer.sv
// Directed and random bursts checked cycle-by-cycle against an expected byte list and line waveform.
module tb_midi_burst_serializer;
  localparam int B = 10;
  typedef logic [7:0] q8_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [20:0] on_arr [5];
  logic [20:0] off_arr [5];
  logic [2:0] on_cnt, off_cnt;
  q8_t q;
  bit chained;

  midi_burst_serializer_if bus();

  midi_burst_serializer #(.CLK_HZ(1000), .BAUD_RATE(100)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] mk(input int st, input int ch, input int note, input int vel);
    return 21'((st << 20) + (ch << 16) + (note << 8) + vel);
  endfunction

  // Expected bytes: offs then ons, counts clamped to 5, data bytes masked to 7 bits
  function automatic q8_t model();
    q8_t r;
    int no = (off_cnt > 3'd5) ? 5 : int'(off_cnt);
    int nn = (on_cnt > 3'd5) ? 5 : int'(on_cnt);
    int e;
    for (int i = 0; i < no + nn; i++) begin
      e = (i < no) ? int'(off_arr[i]) : int'(on_arr[i - no]);
      r.push_back(8'(((i < no) ? 128 : 144) + ((e >> 16) % 16)));
      r.push_back(8'((e >> 8) % 128));
      r.push_back(8'(e % 128));
    end
    return r;
  endfunction

  function automatic logic line_at(input q8_t bytes, input int n);
    int m, bitn, pos, b;
    if (n < 2 || n >= 2 + bytes.size() * 10 * B) return 1'b1;
    m = n - 2;
    bitn = m / B;
    pos = bitn % 10;
    b = int'(bytes[bitn / 10]);
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return 1'((b >> (pos - 1)) % 2);
  endfunction

  task automatic drive();
    for (int i = 0; i < 5; i++) begin
      bus.burst_notes_on_in[i]  = on_arr[i];
      bus.burst_notes_off_in[i] = off_arr[i];
    end
    bus.on_msg_count_in  = on_cnt;
    bus.off_msg_count_in = off_cnt;
  endtask

  task automatic launch();
    drive();
    bus.burst_ready_in = 1'b1;
  endtask

  task automatic rand_burst();
    for (int i = 0; i < 5; i++) begin
      on_arr[i]  = 21'($urandom);
      off_arr[i] = 21'($urandom);
    end
    on_cnt  = 3'($urandom_range(0, 7));
    off_cnt = 3'($urandom_range(0, 7));
  endtask

  // n counts negedges after the capture edge; line starts at n=2, done at n=span+2
  task automatic check_burst(input string name, input q8_t bytes, input int drop_at, input bit chain);
    int span = bytes.size() * 10 * B;
    @(negedge clk);
    bus.burst_ready_in = 1'b0;
    for (int n = 0; n <= span + 3; n++) begin
      chk($sformatf("%s tx@%0d", name, n), 32'(bus.midi_tx_out), 32'(line_at(bytes, n)));
      chk($sformatf("%s busy@%0d", name, n), 32'(bus.busy_out), 32'(n <= span + 1));
      chk($sformatf("%s done@%0d", name, n), 32'(bus.burst_done_out), 32'(n == span + 2));
      chk($sformatf("%s drop@%0d", name, n), 32'(bus.dropped_out), 32'(drop_at >= 0 && n == drop_at + 1));
      if (chain && n == span + 2) begin
        launch();
        return;
      end
      bus.burst_ready_in = (n == drop_at);
      if (n == drop_at) begin
        for (int i = 0; i < 5; i++) begin
          bus.burst_notes_on_in[i]  = 21'($urandom);
          bus.burst_notes_off_in[i] = 21'($urandom);
        end
        bus.on_msg_count_in  = 3'd5;
        bus.off_msg_count_in = 3'd5;
      end
      @(negedge clk);
    end
  endtask

  task automatic set_test1();
    for (int i = 0; i < 5; i++) begin
      on_arr[i]  = '0;
      off_arr[i] = '0;
    end
    on_arr[0] = mk(1, 3, 60, 100);
    on_cnt  = 3'd1;
    off_cnt = 3'd0;
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      on_arr[i]  = '0;
      off_arr[i] = '0;
    end
    on_cnt = '0;
    off_cnt = '0;
    drive();
    bus.burst_ready_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset tx", 32'(bus.midi_tx_out), 32'd1);
    chk("reset busy", 32'(bus.busy_out), 32'd0);
    chk("reset done", 32'(bus.burst_done_out), 32'd0);
    chk("reset drop", 32'(bus.dropped_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    set_test1();
    q = model();
    chk("t1 byte0", 32'(q[0]), 32'h93);
    launch();
    check_burst("t1", q, -1, 1'b0);

    set_test1();
    off_arr[0] = mk(0, 0, 64, 0);
    off_arr[1] = mk(0, 1, 65, 0);
    on_arr[0]  = mk(1, 0, 67, 127);
    off_cnt = 3'd2;
    on_cnt  = 3'd1;
    q = model();
    launch();
    check_burst("t2", q, -1, 1'b0);

    for (int i = 0; i < 5; i++) begin
      on_arr[i]  = mk(1, 15, 200, 255);
      off_arr[i] = mk(1, 15, 200, 255);
    end
    on_cnt  = 3'd7;
    off_cnt = 3'd6;
    q = model();
    launch();
    check_burst("t3", q, -1, 1'b0);

    set_test1();
    q = model();
    launch();
    check_burst("t4", q, 2 + 2 * 10 * B + 35, 1'b0);

    on_cnt  = 3'd0;
    off_cnt = 3'd0;
    q = model();
    launch();
    check_burst("t5", q, -1, 1'b0);

    set_test1();
    launch();
    @(negedge clk);
    bus.burst_ready_in = 1'b0;
    repeat (2 + 4 * B) @(negedge clk);
    chk("t6 pre-reset tx", 32'(bus.midi_tx_out), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 async tx", 32'(bus.midi_tx_out), 32'd1);
    chk("t6 async busy", 32'(bus.busy_out), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6 idle done", 32'(bus.burst_done_out), 32'd0);
    chk("t6 idle tx", 32'(bus.midi_tx_out), 32'd1);
    q = model();
    launch();
    check_burst("t6", q, -1, 1'b0);

    rand_burst();
    launch();
    for (int r = 0; r < 6; r++) begin
      q = model();
      chained = (r % 2 == 0);
      if (chained) rand_burst();
      check_burst($sformatf("rnd%0d", r), q, -1, chained);
      if (!chained && r < 5) begin
        rand_burst();
        launch();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
